// File: rtl/sipo_pkg.sv
// sipo_pkg: loader state encoding and default geometry shared with the SIPO stage.
package sipo_pkg;
  typedef enum logic [1:0] {LOAD, PAD, FULL} state_e;
  localparam int SIPO_WIDTH = 10;
  localparam int SIPO_DEPTH = 64;
endpackage

// File: rtl/sipo_loader.sv
// sipo_loader: streams elements into a downstream SIPO_RAM and holds off input while a full vector waits.
// Defining SIPO_LOADER_LAST_EN adds s_last, which zero-pads a short vector up to DEPTH.
module sipo_loader
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH,
  parameter int DEPTH = SIPO_DEPTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
`ifdef SIPO_LOADER_LAST_EN
  input  logic             s_last,
`endif
  output logic [WIDTH-1:0] sipo_d,
  output logic             sipo_w_en,
  output logic             vec_valid,
  input  logic             vec_ack,
  output logic [CW-1:0]    vec_len
);
  state_e state_q;
  logic [CW-1:0] cnt_q, cnt_d, len_q;
  logic load, acc, at_end;
  always_comb begin
    load = state_q == LOAD;
    acc = load && s_valid;
    cnt_d = cnt_q + CW'(1);
    at_end = cnt_d == CW'(DEPTH);
    s_ready = load;
    sipo_d = load ? s_data : '0;
    sipo_w_en = load ? s_valid : state_q == PAD;
    vec_valid = state_q == FULL;
    vec_len = len_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      case (state_q)
        LOAD: if (acc) begin
          cnt_q <= cnt_d;
          if (at_end) begin
            state_q <= FULL;
            len_q <= CW'(DEPTH);
          end
`ifdef SIPO_LOADER_LAST_EN
          else if (s_last) begin
            state_q <= PAD;
            len_q <= cnt_d;
          end
`endif
        end
        PAD: begin
          cnt_q <= cnt_d;
          if (at_end) state_q <= FULL;
        end
        FULL: if (vec_ack) begin
          state_q <= LOAD;
          cnt_q <= '0;
        end
        default: state_q <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_sipo_loader.sv
// tb_sipo_loader: drives the loader into a behavioural SIPO_RAM and checks against a vector-level model.
module tb_sipo_loader;
  localparam int W = 10;
  localparam int D = 4;
`ifdef SIPO_LOADER_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, vec_ack = 1'b0;
  logic [W-1:0] s_data = '0;
`ifdef SIPO_LOADER_LAST_EN
  logic s_last = 1'b0;
`endif
  logic s_ready, sipo_w_en, vec_valid;
  logic [W-1:0] sipo_d;
  logic [2:0] vec_len;
  logic [W-1:0] q [D];
  int cmp = 0, bad = 0;
  int n = 0, len = 0, pad = 0;
  bit full = 1'b0;
  int exp_w[$];

  sipo_loader #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
`ifdef SIPO_LOADER_LAST_EN
    .s_last(s_last),
`endif
    .sipo_d(sipo_d), .sipo_w_en(sipo_w_en), .vec_valid(vec_valid), .vec_ack(vec_ack), .vec_len(vec_len)
  );

  always #5 clk = ~clk;

  // Downstream SIPO_RAM: each write shifts toward index 0, so the first of DEPTH writes lands in q[0].
  always @(posedge clk) if (sipo_w_en) begin
    for (int i = 0; i < D - 1; i++) q[i] <= q[i+1];
    q[D-1] <= sipo_d;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit rdy();
    return !full && pad == 0;
  endfunction

  task automatic tick(input logic v, input logic [W-1:0] d, input logic l, input logic a, input logic r);
    s_valid = v; s_data = d; vec_ack = a; rst = r;
`ifdef SIPO_LOADER_LAST_EN
    s_last = l;
`endif
    #1;
    if (!r) begin
      chk("s_ready", {31'b0, s_ready}, {31'b0, rdy()});
      chk("sipo_w_en", {31'b0, sipo_w_en}, {31'b0, rdy() ? v : pad > 0});
      if (sipo_w_en === 1'b1) chk("sipo_d", {22'b0, sipo_d}, rdy() ? {22'b0, d} : 32'd0);
    end
    @(posedge clk); #1;
    if (r) begin
      n = 0; full = 0; len = 0; pad = 0;
    end else if (full) begin
      if (a) begin full = 0; n = 0; end
    end else if (pad > 0) begin
      exp_w.push_back(0);
      pad--;
      if (pad == 0) full = 1;
    end else if (v) begin
      exp_w.push_back(int'(d));
      n++;
      if (n == D) begin full = 1; len = D; end
      else if (l && LAST_EN) begin pad = D - n; len = n; end
    end
    chk("vec_valid", {31'b0, vec_valid}, {31'b0, full});
    chk("vec_len", {29'b0, vec_len}, len);
    if (full) for (int i = 0; i < D; i++)
      chk($sformatf("q[%0d]", i), {22'b0, q[i]}, exp_w[exp_w.size() - D + i]);
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom_range(0, (1 << W) - 1));
  endfunction

  initial begin
    tick(0, 0, 0, 0, 1);
    tick(1, rnd(), 0, 1, 1);
    for (int i = 1; i <= D; i++) tick(1, W'(i), 0, 0, 0);
    chk("full_q0", {22'b0, q[0]}, 32'd1);
    chk("full_q3", {22'b0, q[3]}, 32'd4);
    repeat (5) tick(1, rnd(), 0, 0, 0);
    tick(1, rnd(), 0, 1, 0);
    repeat (D) tick(1, rnd(), 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    for (int i = 0; i < 2 * D; i++) tick(i % 2 == 0, rnd(), 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    tick(1, rnd(), 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    tick(1, rnd(), 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    repeat (D) tick(1, rnd(), 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    tick(1, 10'd7, 0, 0, 0);
    tick(1, 10'd8, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    for (int i = 1; i <= D; i++) tick(1, rnd(), i == D, 0, 0);
    tick(0, 0, 0, 1, 0);
    repeat (300) tick(1'($urandom_range(0, 1)), rnd(), $urandom_range(0, 3) == 0,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
